cordic_vector: RTL and testbench

- Vectoring-mode CORDIC. It is the inverse of the sine/cosine rotation engine.
- Takes a Cartesian pair (x_in, y_in) and iteratively rotates it onto the +x axis.
- Returns the polar angle in degrees×1e7, the same fixed-point unit the rotation engine consumes, plus the vector magnitude.
- Sits beside the rotation engine so angles can be round-tripped (angle → sin/cos → angle).

---
 rtl/cordic_pkg.sv | 44 ++++
 rtl/cordic_vec_iter.sv | 37 +++
 rtl/cordic_vector.sv | 137 +++++++++++++
 tb/tb_cordic_vector.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: atan table, angle constants, gain inverse and FSM
// state encoding. Used by both the rotation and the vectoring engines.
package cordic_pkg;

  // Depth of the atan table. The vectoring engine supports ITER up to this value.
  localparam int ATAN_DEPTH = 16;

  // 180 degrees in degrees x 1e7.
  localparam logic signed [31:0] ANGLE_180 = 32'sd1800000000;

  // round(65536 / K), where K ~= 1.646760 is the CORDIC gain.
  localparam logic [15:0] GAIN_INV = 16'd39797;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } cordic_state_t;

  // round(atan(2^-i) in degrees x 1e7); indices past the table return 0.
  function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 32'sd450000000;
      5'd1:    atan_lut = 32'sd265650512;
      5'd2:    atan_lut = 32'sd140362435;
      5'd3:    atan_lut = 32'sd71250163;
      5'd4:    atan_lut = 32'sd35763344;
      5'd5:    atan_lut = 32'sd17899106;
      5'd6:    atan_lut = 32'sd8951737;
      5'd7:    atan_lut = 32'sd4476142;
      5'd8:    atan_lut = 32'sd2238105;
      5'd9:    atan_lut = 32'sd1119057;
      5'd10:   atan_lut = 32'sd559529;
      5'd11:   atan_lut = 32'sd279765;
      5'd12:   atan_lut = 32'sd139882;
      5'd13:   atan_lut = 32'sd69941;
      5'd14:   atan_lut = 32'sd34971;
      5'd15:   atan_lut = 32'sd17485;
      default: atan_lut = 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_vec_iter.sv
// One combinational vectoring micro-rotation: drives y toward zero and
// accumulates the applied rotation into z.
module cordic_vec_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] z,
  input  logic [4:0]              i,
  output logic signed [WIDTH-1:0] x_next,
  output logic signed [WIDTH-1:0] y_next,
  output logic signed [WIDTH-1:0] z_next
);

  logic signed [WIDTH-1:0] x_sh;
  logic signed [WIDTH-1:0] y_sh;
  logic signed [WIDTH-1:0] step;

  // Rotate clockwise when y is non-negative, counter-clockwise otherwise.
  always_comb begin
    x_sh = x >>> i;
    y_sh = y >>> i;
    step = WIDTH'(atan_lut(i));
    if (!y[WIDTH-1]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + step;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - step;
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// Vectoring-mode CORDIC: converts (x_in, y_in) to angle (degrees x 1e7) and
// K-scaled magnitude. Defining CORDIC_VECTOR_GAIN_COMP_EN adds a one-cycle
// COMP state that removes the CORDIC gain from the magnitude.
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 16   // must not exceed ATAN_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             done,
  output logic [WIDTH-1:0] angle,
  output logic [WIDTH-1:0] magnitude
);

  localparam logic signed [WIDTH-1:0] Z_180 = WIDTH'(ANGLE_180);

  cordic_state_t state, state_next;

  logic signed [WIDTH-1:0] x_q, y_q, z_q;
  logic signed [WIDTH-1:0] x_nx, y_nx, z_nx;
  logic [4:0]              cnt;
  logic                    zero_q;
  logic                    iter_last;
  logic                    x_neg, y_neg;

  // The counter reaching ITER means every micro-rotation has been applied.
  assign iter_last = (cnt == 5'(ITER));
  assign x_neg     = x_in[WIDTH-1];
  assign y_neg     = y_in[WIDTH-1];
  assign done      = (state == ST_DONE);

  cordic_vec_iter #(.WIDTH(WIDTH)) u_iter (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .i      (cnt),
    .x_next (x_nx),
    .y_next (y_nx),
    .z_next (z_nx)
  );

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  localparam int PW = WIDTH + 16;

  logic signed [PW-1:0]    prod;
  logic signed [WIDTH-1:0] mag_comp;

  // Divide out the CORDIC gain: (x * round(65536/K)) >>> 16.
  always_comb begin
    prod     = PW'(x_q) * $signed({{(PW-16){1'b0}}, GAIN_INV});
    mag_comp = WIDTH'(prod >>> 16);
  end
`endif

  // State register; reset aborts any computation in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: load on start, iterate, optionally compensate, hold result.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (s) state_next = ST_ITER;
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
      ST_ITER: if (iter_last) state_next = ST_COMP;
      ST_COMP: state_next = ST_DONE;
`else
      ST_ITER: if (iter_last) state_next = ST_DONE;
`endif
      ST_DONE: if (!s) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: pre-rotated load, micro-rotations, and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      cnt       <= '0;
      zero_q    <= 1'b0;
      angle     <= '0;
      magnitude <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s) begin
            cnt    <= '0;
            zero_q <= (x_in == '0) && (y_in == '0);
            if (x_neg) begin
              // Left half-plane: rotate by 180 degrees so x starts non-negative.
              x_q <= -$signed(x_in);
              y_q <= -$signed(y_in);
              z_q <= y_neg ? -Z_180 : Z_180;
            end else begin
              x_q <= $signed(x_in);
              y_q <= $signed(y_in);
              z_q <= '0;
            end
          end
        end
        ST_ITER: begin
          if (!iter_last) begin
            x_q <= x_nx;
            y_q <= y_nx;
            z_q <= z_nx;
            cnt <= cnt + 5'd1;
          end else begin
`ifndef CORDIC_VECTOR_GAIN_COMP_EN
            angle     <= zero_q ? '0 : z_q;
            magnitude <= zero_q ? '0 : x_q;
`endif
          end
        end
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
        ST_COMP: begin
          angle     <= zero_q ? '0 : z_q;
          magnitude <= zero_q ? '0 : mag_comp;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector: directed corner vectors, handshake
// variants, mid-run reset and randomized vectors against a real-valued model.
module tb_cordic_vector;

`ifdef CORDIC_VECTOR_GAIN_COMP_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif
  localparam real PI     = 3.14159265358979323846;
  localparam real K_GAIN = 1.646760;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s = 1'b0;
  logic [31:0] x_in = '0;
  logic [31:0] y_in = '0;
  logic        done;
  logic [31:0] angle;
  logic [31:0] magnitude;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cordic_vector dut (
    .clk       (clk),
    .rst       (rst),
    .s         (s),
    .x_in      (x_in),
    .y_in      (y_in),
    .done      (done),
    .angle     (angle),
    .magnitude (magnitude)
  );

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol);
    longint d;
    d = got - exp;
    if (d < 0) d = -d;
    n_checks++;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Reference: polar conversion with real arithmetic.
  function automatic void model(input int xi, input int yi,
                                output longint ea, output longint em,
                                output longint ta, output longint tm);
    real a, r;
    if (xi == 0 && yi == 0) begin
      ea = 0; em = 0; ta = 0; tm = 0;
      return;
    end
    a = $atan2(real'(yi), real'(xi)) * 180.0 / PI * 1.0e7;
    r = $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi)) * K_GAIN;
`ifdef CORDIC_VECTOR_GAIN_COMP_EN
    r = r * 39797.0 / 65536.0;
`endif
    ea = longint'(a);
    em = longint'(r);
    ta = 40000;
    tm = longint'(r * 2.0e-4) + 2;
  endfunction

  // One transaction; hold = cycles s stays high after done (0 = 1-cycle start pulse).
  task automatic run(input int xi, input int yi, input int hold, input string tag);
    longint ea, em, ta, tm;
    int k;
    model(xi, yi, ea, em, ta, tm);
    @(negedge clk);
    x_in = xi; y_in = yi; s = 1'b1;
    @(negedge clk);                      // load edge has passed
    x_in = $urandom; y_in = $urandom;    // must be ignored
    if (hold == 0) s = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, k, LAT, 0);
    check({tag, "_angle"}, $signed(angle), ea, ta);
    check({tag, "_mag"}, $signed(magnitude), em, tm);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_done_hold"}, done, 1, 0);
      check({tag, "_angle_hold"}, $signed(angle), ea, ta);
      check({tag, "_mag_hold"}, $signed(magnitude), em, tm);
    end
    if (hold > 0) begin
      @(negedge clk);
      s = 1'b0;
    end
    @(posedge clk); #1;
    check({tag, "_done_drop"}, done, 0, 0);
    check({tag, "_angle_idle"}, $signed(angle), ea, ta);
    check({tag, "_mag_idle"}, $signed(magnitude), em, tm);
  endtask

  initial begin
    int xi, yi;
    real r2;

    #1 rst = 1'b1;
    #1;
    check("rst_done", done, 0, 0);
    check("rst_angle", $signed(angle), 0, 0);
    check("rst_mag", $signed(magnitude), 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(10000000, 10000000, 3, "diag45");
    run(0, 20000000, 1, "up90");
    run(10000000, -17320508, 0, "neg60");
    run(-10000000, 0, 1, "pos180");
    run(-10000000, -1, 0, "neg180");
    run(0, 0, 1, "zero");

    // Abort mid-iteration with a non-zero result still on the outputs.
    run(5000000, 3000000, 0, "pre_rst");
    @(negedge clk);
    x_in = 30000000; y_in = -20000000; s = 1'b1;
    @(negedge clk);                      // load edge has passed
    repeat (8) @(posedge clk);           // counter now at 8
    #2 rst = 1'b1;
    #1;
    check("midrst_done", done, 0, 0);
    check("midrst_angle", $signed(angle), 0, 0);
    check("midrst_mag", $signed(magnitude), 0, 0);
    @(negedge clk);
    s = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("midrst_idle_done", done, 0, 0);
    run(10000000, 10000000, 1, "post_rst");

    for (int n = 0; n < 20; n++) begin
      do begin
        xi = int'($urandom_range(0, 536870910)) - 268435455;
        yi = int'($urandom_range(0, 536870910)) - 268435455;
        r2 = real'(xi) * real'(xi) + real'(yi) * real'(yi);
      end while (r2 < 1.0e14);
      run(xi, yi, int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
